// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared processor definitions: hazard-controller state encoding, drain-counter
// width, forwarding-select encodings and the pipeline control bundle.
package pipeline_hazard_controller_pkg;

    localparam int DRAIN_CNT_W = 4;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_DRAIN    = 2'd2;
    localparam logic [1:0] ST_SWITCH   = 2'd3;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic pc_stall;
        logic if_id_stall;
        logic id_ex_bubble;
        logic if_id_flush;
        logic global_stall;
    } hz_ctrl_t;

endpackage

// File: rtl/pipeline_hazard_controller_hazard_compare.sv
// Load-use comparator: flags an ID-stage source that depends on the load in EX.
module hazard_compare #(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  mem_read_EX,
    input  logic [REG_ADDR_W-1:0] wb_address_EX,
    input  logic [REG_ADDR_W-1:0] address1_ID,
    input  logic [REG_ADDR_W-1:0] address2_ID,
    input  logic                  use_rs1_ID,
    input  logic                  use_rs2_ID,
    output logic                  load_use
);

    logic rs1_match;
    logic rs2_match;

    assign rs1_match = use_rs1_ID && (address1_ID == wb_address_EX);
    assign rs2_match = use_rs2_ID && (address2_ID == wb_address_EX);

    // x0 is hard-wired zero, so a load targeting it never creates a dependency.
    assign load_use = mem_read_EX && (wb_address_EX != '0) && (rs1_match || rs2_match);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller: load-use stalls, branch flushes, cache-miss freeze
// and the drain/switch sequence used for a context-driven cache bank switch.
module pipeline_hazard_controller
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int REG_ADDR_W   = 5,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  mem_read_EX,
    input  logic [REG_ADDR_W-1:0] wb_address_EX,
    input  logic [REG_ADDR_W-1:0] address1_ID,
    input  logic [REG_ADDR_W-1:0] address2_ID,
    input  logic                  use_rs1_ID,
    input  logic                  use_rs2_ID,
    input  logic                  branch_taken_EX,
    input  logic                  icache_busy,
    input  logic                  dcache_busy,
    input  logic                  ctx_switch_req,
    input  logic                  cache_switch_done,
    output logic                  pc_stall,
    output logic                  if_id_stall,
    output logic                  id_ex_bubble,
    output logic                  if_id_flush,
    output logic                  global_stall,
    output logic                  hazard_detect_signal,
    output logic                  cache_switch_start,
    output logic                  ctx_switch_ack,
    output logic                  busy
);

    localparam logic [DRAIN_CNT_W-1:0] DRAIN_LOAD = DRAIN_CNT_W'(DRAIN_CYCLES);
    localparam logic [DRAIN_CNT_W-1:0] CNT_ONE    = {{(DRAIN_CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]             state_q, state_d;
    logic [DRAIN_CNT_W-1:0] cnt_q, cnt_d;
    logic                   hd_q, hd_d;
    logic                   start_q, start_d;

    logic     load_use;
    logic     cache_busy;
    logic     run_like;
    logic     ack;
    hz_ctrl_t ctrl;

    hazard_compare #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard_compare (
        .mem_read_EX   (mem_read_EX),
        .wb_address_EX (wb_address_EX),
        .address1_ID   (address1_ID),
        .address2_ID   (address2_ID),
        .use_rs1_ID    (use_rs1_ID),
        .use_rs2_ID    (use_rs2_ID),
        .load_use      (load_use)
    );

    assign cache_busy = icache_busy | dcache_busy;
    // The MEM_WAIT exit cycle behaves as a normal RUN cycle for the pipeline.
    assign run_like   = (state_q == ST_RUN) || (state_q == ST_MEM_WAIT);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hd_d    = hd_q;
        start_d = 1'b0;
        ack     = 1'b0;
        ctrl    = '0;
        if (state_q == ST_SWITCH) begin
            ctrl.pc_stall     = 1'b1;
            ctrl.global_stall = 1'b1;
            if (cache_switch_done) begin
                ack     = 1'b1;
                state_d = ST_RUN;
            end
        end else if (cache_busy) begin
            // Full freeze: counter and hazard flag hold until the miss resolves.
            ctrl.global_stall = 1'b1;
            if (state_q == ST_RUN) begin
                state_d = ST_MEM_WAIT;
            end
        end else begin
            if (branch_taken_EX) begin
                ctrl.if_id_flush  = 1'b1;
                ctrl.id_ex_bubble = 1'b1;
            end else if (run_like && load_use) begin
                ctrl.pc_stall     = 1'b1;
                ctrl.if_id_stall  = 1'b1;
                ctrl.id_ex_bubble = 1'b1;
            end
            hd_d = run_like && !branch_taken_EX && load_use;
            case (state_q)
                ST_RUN: begin
                    if (ctx_switch_req) begin
                        state_d = ST_DRAIN;
                        cnt_d   = DRAIN_LOAD;
                    end
                end
                ST_MEM_WAIT: state_d = ST_RUN;
                default: begin
                    ctrl.pc_stall     = 1'b1;
                    ctrl.id_ex_bubble = 1'b1;
                    cnt_d             = cnt_q - CNT_ONE;
                    if (cnt_q <= CNT_ONE) begin
                        cnt_d   = '0;
                        state_d = ST_SWITCH;
                        start_d = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            hd_q    <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hd_q    <= hd_d;
            start_q <= start_d;
        end
    end

    assign pc_stall             = ~RESET & ctrl.pc_stall;
    assign if_id_stall          = ~RESET & ctrl.if_id_stall;
    assign id_ex_bubble         = ~RESET & ctrl.id_ex_bubble;
    assign if_id_flush          = ~RESET & ctrl.if_id_flush;
    assign global_stall         = ~RESET & ctrl.global_stall;
    assign hazard_detect_signal = ~RESET & hd_q & ~ctrl.global_stall;
    assign cache_switch_start   = ~RESET & start_q;
    assign ctx_switch_ack       = ~RESET & ack;
    assign busy                 = ~RESET & (state_q != ST_RUN);

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller; outputs are checked as one
// 9-bit vector {pc_stall,if_id_stall,id_ex_bubble,if_id_flush,global_stall,hd,start,ack,busy}.
module tb_pipeline_hazard_controller;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       mem_read_EX;
    logic [4:0] wb_address_EX;
    logic [4:0] address1_ID;
    logic [4:0] address2_ID;
    logic       use_rs1_ID;
    logic       use_rs2_ID;
    logic       branch_taken_EX;
    logic       icache_busy;
    logic       dcache_busy;
    logic       ctx_switch_req;
    logic       cache_switch_done;
    logic       pc_stall, if_id_stall, id_ex_bubble, if_id_flush, global_stall;
    logic       hazard_detect_signal, cache_switch_start, ctx_switch_ack, busy;

    int err_cnt = 0;
    int chk_cnt = 0;

    pipeline_hazard_controller dut (
        .CLK                  (CLK),
        .RESET                (RESET),
        .mem_read_EX          (mem_read_EX),
        .wb_address_EX        (wb_address_EX),
        .address1_ID          (address1_ID),
        .address2_ID          (address2_ID),
        .use_rs1_ID           (use_rs1_ID),
        .use_rs2_ID           (use_rs2_ID),
        .branch_taken_EX      (branch_taken_EX),
        .icache_busy          (icache_busy),
        .dcache_busy          (dcache_busy),
        .ctx_switch_req       (ctx_switch_req),
        .cache_switch_done    (cache_switch_done),
        .pc_stall             (pc_stall),
        .if_id_stall          (if_id_stall),
        .id_ex_bubble         (id_ex_bubble),
        .if_id_flush          (if_id_flush),
        .global_stall         (global_stall),
        .hazard_detect_signal (hazard_detect_signal),
        .cache_switch_start   (cache_switch_start),
        .ctx_switch_ack       (ctx_switch_ack),
        .busy                 (busy)
    );

    always #5 CLK = ~CLK;

    wire [8:0] outs = {pc_stall, if_id_stall, id_ex_bubble, if_id_flush, global_stall,
                       hazard_detect_signal, cache_switch_start, ctx_switch_ack, busy};

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %b want %b", tag, obs, exp);
        end else begin
            $display("ok   %s: %b", tag, obs);
        end
    endtask

    // Inputs are applied just after a rising edge; outputs are sampled on the falling edge.
    task automatic vec(input string tag, input logic [8:0] exp);
        @(negedge CLK);
        check(tag, outs, exp);
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        mem_read_EX       = 1'b0;
        wb_address_EX     = '0;
        address1_ID       = '0;
        address2_ID       = '0;
        use_rs1_ID        = 1'b0;
        use_rs2_ID        = 1'b0;
        branch_taken_EX   = 1'b0;
        icache_busy       = 1'b0;
        dcache_busy       = 1'b0;
        ctx_switch_req    = 1'b0;
        cache_switch_done = 1'b0;
    endtask

    task automatic lu(input logic [4:0] wb, input logic [4:0] a1, input logic [4:0] a2,
                      input logic u1, input logic u2);
        idle();
        mem_read_EX   = 1'b1;
        wb_address_EX = wb;
        address1_ID   = a1;
        address2_ID   = a2;
        use_rs1_ID    = u1;
        use_rs2_ID    = u2;
    endtask

    initial begin
        // Reset with every input active: all outputs must stay low.
        RESET = 1'b1;
        lu(5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
        dcache_busy    = 1'b1;
        branch_taken_EX = 1'b1;
        ctx_switch_req = 1'b1;
        vec("reset_outs", 9'b000_000_000);
        idle();
        RESET = 1'b0;
        vec("run_idle", 9'b000_000_000);

        // Load-use on rs1 and on rs2, hazard flag one cycle later only.
        lu(5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
        vec("lu_rs1_stall", 9'b111_000_000);
        idle();
        vec("lu_rs1_hd", 9'b000_001_000);
        vec("lu_rs1_hd_clr", 9'b000_000_000);
        lu(5'd7, 5'd3, 5'd7, 1'b1, 1'b1);
        vec("lu_rs2_stall", 9'b111_000_000);
        idle();
        vec("lu_rs2_hd", 9'b000_001_000);
        lu(5'd7, 5'd0, 5'd7, 1'b0, 1'b0);
        vec("lu_use_off", 9'b000_000_000);
        lu(5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
        mem_read_EX = 1'b0;
        vec("no_load", 9'b000_000_000);

        // Load into x0 never stalls.
        lu(5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
        vec("x0_stall", 9'b000_000_000);
        idle();
        vec("x0_hd", 9'b000_000_000);

        // Branch wins over load-use.
        lu(5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
        branch_taken_EX = 1'b1;
        vec("br_over_lu", 9'b001_100_000);
        idle();
        vec("br_no_hd", 9'b000_000_000);

        // dcache miss for 4 cycles during a load-use hazard.
        lu(5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
        dcache_busy = 1'b1;
        vec("dc_busy_run", 9'b000_010_000);
        vec("dc_busy_w1", 9'b000_010_001);
        vec("dc_busy_w2", 9'b000_010_001);
        vec("dc_busy_w3", 9'b000_010_001);
        dcache_busy = 1'b0;
        vec("dc_exit_lu", 9'b111_000_001);
        idle();
        vec("dc_exit_hd", 9'b000_001_000);

        // icache miss beats a branch.
        idle();
        icache_busy     = 1'b1;
        branch_taken_EX = 1'b1;
        vec("ic_over_br", 9'b000_010_000);
        idle();
        vec("ic_exit", 9'b000_000_001);
        vec("ic_run", 9'b000_000_000);

        // Context switch: 3 drain cycles (one frozen by dcache), then SWITCH.
        ctx_switch_req = 1'b1;
        vec("sw_req_run", 9'b000_000_000);
        vec("sw_drain1", 9'b101_000_001);
        ctx_switch_req = 1'b0;
        dcache_busy    = 1'b1;
        vec("sw_drain_frz", 9'b000_010_001);
        dcache_busy = 1'b0;
        vec("sw_drain2", 9'b101_000_001);
        branch_taken_EX = 1'b1;
        vec("sw_drain3_br", 9'b101_100_001);
        idle();
        vec("sw_start", 9'b100_010_101);
        for (int i = 1; i <= 4; i++) begin
            vec($sformatf("sw_wait%0d", i), 9'b100_010_001);
        end
        cache_switch_done = 1'b1;
        vec("sw_ack", 9'b100_010_011);
        cache_switch_done = 1'b0;
        vec("sw_back_run", 9'b000_000_000);
        cache_switch_done = 1'b1;
        vec("stray_done_run", 9'b000_000_000);
        idle();
        vec("stray_done_after", 9'b000_000_000);

        // Reset while in SWITCH aborts without ack.
        ctx_switch_req = 1'b1;
        vec("rs_req_run", 9'b000_000_000);
        ctx_switch_req = 1'b0;
        vec("rs_drain1", 9'b101_000_001);
        vec("rs_drain2", 9'b101_000_001);
        vec("rs_drain3", 9'b101_000_001);
        vec("rs_start", 9'b100_010_101);
        RESET             = 1'b1;
        cache_switch_done = 1'b1;
        vec("rs_in_switch", 9'b000_000_000);
        RESET = 1'b0;
        vec("rs_stray_done", 9'b000_000_000);
        idle();
        vec("rs_run_idle", 9'b000_000_000);
        lu(5'd9, 5'd0, 5'd9, 1'b0, 1'b1);
        vec("rs_lu_stall", 9'b111_000_000);
        idle();
        vec("rs_lu_hd", 9'b000_001_000);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_controller.md
PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 5: register address width.
REQ-002 SHALL have parameter DRAIN_CYCLES, default 3: number of bubble cycles inserted before a cache switch; legal range 1..15.
REQ-003 SHALL have port CLK, input, 1: the single clock; all state updates on rising edge.
REQ-004 SHALL have port RESET, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have ports mem_read_EX (input, 1) and wb_address_EX (input, REG_ADDR_W): the EX-stage instruction is a load, and its destination register.
REQ-006 SHALL have ports address1_ID and address2_ID (input, REG_ADDR_W), and use_rs1_ID and use_rs2_ID (input, 1): the ID-stage source registers and their valid flags.
REQ-007 SHALL have ports branch_taken_EX, icache_busy and dcache_busy (input, 1 each): EX redirect, instruction-cache miss in progress, data-cache miss in progress.
REQ-008 SHALL have ports ctx_switch_req (input, 1), a level request from the CSR, and cache_switch_done (input, 1), a one-cycle pulse from the cache bank.
REQ-009 SHALL have ports pc_stall, if_id_stall, id_ex_bubble, if_id_flush, global_stall and hazard_detect_signal (output, 1 each).
REQ-010 SHALL have ports cache_switch_start and ctx_switch_ack (output, 1 each, single-cycle pulses) and busy (output, 1).

Function
REQ-011 SHALL implement states RUN, MEM_WAIT, DRAIN and SWITCH.
REQ-012 In any state other than SWITCH, icache_busy or dcache_busy high SHALL assert global_stall combinationally in the same cycle; this freezes every pipeline register and PC, and no other output is asserted that cycle.
REQ-013 In RUN, a busy input SHALL cause a transition to MEM_WAIT. MEM_WAIT SHALL return to RUN in the first cycle where both busy inputs are low, and global_stall is low in that cycle.
REQ-014 A load-use hazard is defined as: in RUN, mem_read_EX=1, wb_address_EX!=0, and (use_rs1_ID and address1_ID==wb_address_EX, or use_rs2_ID and address2_ID==wb_address_EX).
REQ-015 On a load-use hazard, pc_stall, if_id_stall and id_ex_bubble SHALL be asserted combinationally for exactly that cycle.
REQ-016 hazard_detect_signal SHALL be a register set on the edge ending a load-use stall cycle and cleared on the next edge; it is high for exactly one cycle, while the bubble sits in EX, to suppress MEM forwarding.
REQ-017 In RUN or DRAIN, branch_taken_EX=1 SHALL assert if_id_flush and id_ex_bubble in the same cycle.
REQ-018 A branch SHALL take priority over a load-use hazard: pc_stall and if_id_stall stay low, and hazard_detect_signal is not set.
REQ-019 Priority SHALL be: reset > cache busy > branch > load-use.
REQ-020 In RUN with ctx_switch_req=1 and no busy input, the controller SHALL load the drain counter with DRAIN_CYCLES and enter DRAIN.
REQ-021 In DRAIN, pc_stall and id_ex_bubble SHALL be held high and the counter SHALL decrement every non-global-stall cycle. When the counter reaches 0, the controller SHALL enter SWITCH and pulse cache_switch_start in the first SWITCH cycle.
REQ-022 SWITCH SHALL hold pc_stall and global_stall high until cache_switch_done. In that cycle it SHALL pulse ctx_switch_ack and return to RUN.
REQ-023 A ctx_switch_req still high after ack SHALL start a new switch only after one full RUN cycle.
REQ-024 ctx_switch_req falling during DRAIN or SWITCH SHALL be ignored; a started switch always completes.
REQ-025 cache_switch_done outside SWITCH SHALL be ignored.
REQ-026 busy SHALL be high whenever the state is not RUN.

Reset
REQ-027 RESET high SHALL asynchronously force state RUN, drain counter 0, and hazard_detect_signal 0.
REQ-028 During reset, all outputs SHALL be 0.
REQ-029 Reset asserted during DRAIN or SWITCH SHALL abort the switch with no ack.

Structure
REQ-030 The state encoding and the drain-counter width (4 bits) SHALL live in the shared processor package, alongside the forwarding-select encodings.
REQ-031 A sub-module hazard_compare SHALL contain the combinational load-use comparator (REQ-014); the FSM and the counter SHALL stay in the top module.

Verification
REQ-032 Load x5 in EX, ID uses rs1=x5 -> pc_stall, if_id_stall and id_ex_bubble high for 1 cycle; hazard_detect_signal high the next cycle only.
REQ-033 Load x0 in EX, ID uses x0 -> no stall and hazard_detect_signal stays 0.
REQ-034 Load-use hazard and branch_taken_EX in the same cycle -> if_id_flush and id_ex_bubble high, pc_stall low, hazard_detect_signal stays 0.
REQ-035 dcache_busy high for 4 cycles during a load-use hazard -> global_stall high for those 4 cycles only; the load-use stall appears in the first cycle after dcache_busy falls.
REQ-036 ctx_switch_req with DRAIN_CYCLES=3 -> 3 DRAIN cycles, cache_switch_start pulse, wait; cache_switch_done arriving 5 cycles later -> ctx_switch_ack pulse in that same cycle, then RUN.
REQ-037 RESET asserted in SWITCH -> immediately RUN, all outputs 0, no ctx_switch_ack; a later stray cache_switch_done is ignored.
